// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return sequencing for a single-hart core.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_trap_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_en,
  input  logic [2:0]         func3,
  input  logic [11:0]        offset,
  input  logic [4:0]         rs1_idx,
  input  logic [XLEN-1:0]    rs1_val,
  output logic [XLEN-1:0]    csr_out,
  output logic               csr_illegal,
  input  logic               ext_irq,
  input  logic               tmr_irq,
  input  logic               sw_irq,
  input  logic [NUM_IRQ-1:0] local_irq,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic               ret_action,
  input  logic [XLEN-1:0]    current_pc,
  input  logic               instr_retire,
  output logic               trap_req,
  input  logic               trap_ack,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               MIE
);

  if (XLEN != 32) begin : g_xlen_check
    $error("csr_trap_unit supports only XLEN == 32");
  end
  if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_irq_check
    $error("csr_trap_unit supports NUM_IRQ in 1..16");
  end

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMie      = 12'h304;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMip      = 12'h344;
  localparam logic [11:0] AddrMcycle   = 12'hB00;
  localparam logic [11:0] AddrMinstret = 12'hB02;
  localparam logic [11:0] AddrMcycleh  = 12'hB80;
  localparam logic [11:0] AddrMinstreth = 12'hB82;

  localparam logic [15:0]     LocalMask = 16'((17'd1 << NUM_IRQ) - 17'd1);
  localparam logic [XLEN-1:0] MieMask   = XLEN'({LocalMask, 16'h0888});

  logic            mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mepc_q, mscratch_q, mcause_q;
  logic [XLEN-1:0] mip, pending, rdata, src, new_val, base;
  logic            hit, wr_req, illegal_raw, csr_we, irq_any, is_irq, trap_fire;
  logic [4:0]      code;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  always_comb begin
    mip = '0;
    mip[11] = ext_irq;
    mip[7]  = tmr_irq;
    mip[3]  = sw_irq;
    mip[16 +: NUM_IRQ] = local_irq;
  end

  assign pending = mip & mie_q;
  assign irq_any = mstatus_mie && (|pending);

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    unique case (offset)
      AddrMstatus: begin
        rdata[3] = mstatus_mie;
        rdata[7] = mstatus_mpie;
      end
      AddrMie:      rdata = mie_q;
      AddrMtvec:    rdata = mtvec_q;
      AddrMscratch: rdata = mscratch_q;
      AddrMepc:     rdata = mepc_q;
      AddrMcause:   rdata = mcause_q;
      AddrMip:      rdata = mip;
`ifdef CSR_COUNTERS_EN
      AddrMcycle:    rdata = mcycle_q[31:0];
      AddrMcycleh:   rdata = mcycle_q[63:32];
      AddrMinstret:  rdata = minstret_q[31:0];
      AddrMinstreth: rdata = minstret_q[63:32];
`else
      AddrMcycle, AddrMcycleh, AddrMinstret, AddrMinstreth: rdata = '0;
`endif
      default:      hit = 1'b0;
    endcase
  end

  assign csr_out = rdata;
  assign src     = func3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_val;
  assign wr_req  = (func3[1:0] == 2'b01) || (rs1_idx != 5'd0);

  always_comb begin
    unique case (func3[1:0])
      2'b10:   new_val = rdata | src;
      2'b11:   new_val = rdata & ~src;
      default: new_val = src;
    endcase
  end

  assign illegal_raw = csr_en && ((func3[1:0] == 2'b00) || !hit ||
                                  (offset == AddrMip && wr_req));
  assign csr_illegal = !reset && illegal_raw;

  // Exception first, then ext > sw > tmr > local with the lowest local index winning.
  always_comb begin
    is_irq = 1'b1;
    code   = 5'd0;
    if (exc_valid) begin
      is_irq = 1'b0;
      code   = exc_code;
    end else if (pending[11]) begin
      code = 5'd11;
    end else if (pending[3]) begin
      code = 5'd3;
    end else if (pending[7]) begin
      code = 5'd7;
    end else begin
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (pending[16 + i]) code = 5'(16 + i);
      end
    end
  end

  assign trap_req  = !reset && (exc_valid || irq_any);
  assign trap_fire = trap_ack && trap_req;
  assign csr_we    = csr_en && !illegal_raw && wr_req && !trap_fire && !ret_action;
  assign redirect  = !reset && (trap_fire || ret_action);
  assign base      = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    if (trap_fire) begin
      redirect_pc = (mtvec_q[0] && is_irq) ? base + {{(XLEN-7){1'b0}}, code, 2'b00} : base;
    end else begin
      redirect_pc = mepc_q;
    end
  end

  assign MIE = mstatus_mie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= '0;
      mepc_q       <= '0;
      mscratch_q   <= '0;
      mcause_q     <= '0;
    end else if (trap_fire) begin
      mepc_q       <= current_pc;
      mcause_q     <= {is_irq, {(XLEN-6){1'b0}}, code};
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (ret_action) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we) begin
      unique case (offset)
        AddrMstatus: begin
          mstatus_mie  <= new_val[3];
          mstatus_mpie <= new_val[7];
        end
        AddrMie:      mie_q      <= new_val & MieMask;
        AddrMtvec:    mtvec_q    <= {new_val[XLEN-1:2], 1'b0, new_val[0]};
        AddrMscratch: mscratch_q <= new_val;
        AddrMepc:     mepc_q     <= {new_val[XLEN-1:2], 2'b00};
        AddrMcause:   mcause_q   <= new_val;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to either half replaces that cycle's increment of the whole counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_we && offset == AddrMcycle) begin
        mcycle_q[31:0] <= new_val;
      end else if (csr_we && offset == AddrMcycleh) begin
        mcycle_q[63:32] <= new_val;
      end else begin
        mcycle_q <= mcycle_q + 64'd1;
      end
      if (csr_we && offset == AddrMinstret) begin
        minstret_q[31:0] <= new_val;
      end else if (csr_we && offset == AddrMinstreth) begin
        minstret_q[63:32] <= new_val;
      end else if (instr_retire) begin
        minstret_q <= minstret_q + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit; counter checks follow CSR_COUNTERS_EN.
module tb_csr_trap_unit;

  logic        clk = 1'b0, reset = 1'b0, csr_en = 1'b0;
  logic [2:0]  func3 = '0;
  logic [11:0] offset = '0;
  logic [4:0]  rs1_idx = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] csr_out;
  logic        csr_illegal;
  logic        ext_irq = 1'b0, tmr_irq = 1'b0, sw_irq = 1'b0;
  logic [7:0]  local_irq = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic        ret_action = 1'b0;
  logic [31:0] current_pc = '0;
  logic        instr_retire = 1'b0;
  logic        trap_req, trap_ack = 1'b0, redirect;
  logic [31:0] redirect_pc;
  logic        mie_out;

  int checks = 0;
  int failures = 0;

  logic [11:0] csr_addrs [7] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344};

  csr_trap_unit #(.XLEN(32), .NUM_IRQ(8)) dut (
    .clk(clk), .reset(reset), .csr_en(csr_en), .func3(func3), .offset(offset),
    .rs1_idx(rs1_idx), .rs1_val(rs1_val), .csr_out(csr_out), .csr_illegal(csr_illegal),
    .ext_irq(ext_irq), .tmr_irq(tmr_irq), .sw_irq(sw_irq), .local_irq(local_irq),
    .exc_valid(exc_valid), .exc_code(exc_code), .ret_action(ret_action),
    .current_pc(current_pc), .instr_retire(instr_retire), .trap_req(trap_req),
    .trap_ack(trap_ack), .redirect(redirect), .redirect_pc(redirect_pc), .MIE(mie_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csr_en = 1'b1; func3 = 3'b010; offset = a; rs1_idx = 5'd0;
    #1;
    d = csr_out;
    csr_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                    input logic [31:0] v, output logic [31:0] old, output logic ill);
    csr_en = 1'b1; func3 = f3; offset = a; rs1_idx = idx; rs1_val = v;
    #1;
    old = csr_out;
    ill = csr_illegal;
    step();
    csr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    csr_en = 1'b1; func3 = 3'b000; offset = 12'h123; exc_valid = 1'b1;
    ret_action = 1'b1; trap_ack = 1'b1; tmr_irq = 1'b1;
    #1;
    checks++; if (trap_req !== 1'b0) begin failures++; $display("FAIL rst_trap_req got=%b exp=0", trap_req); end
    checks++; if (csr_illegal !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%b exp=0", csr_illegal); end
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%b exp=0", redirect); end
    csr_en = 1'b0; exc_valid = 1'b0; ret_action = 1'b0; trap_ack = 1'b0; tmr_irq = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd(csr_addrs[i], d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_csr_%h got=%h exp=0", csr_addrs[i], d); end
    end
    checks++; if (mie_out !== 1'b0) begin failures++; $display("FAIL rst_mie got=%b exp=0", mie_out); end
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_mtvec_rw();
    logic [31:0] d, old;
    logic ill;
    wr(3'b001, 12'h305, 5'd1, 32'h8000_0101, old, ill);
    checks++; if (old !== 32'h0) begin failures++; $display("FAIL mtvec_old got=%h exp=0", old); end
    checks++; if (ill !== 1'b0) begin failures++; $display("FAIL mtvec_ill got=%b exp=0", ill); end
    rd(12'h305, d);
    checks++; if (d !== 32'h8000_0101) begin failures++; $display("FAIL mtvec_rd got=%h exp=80000101", d); end
    wr(3'b001, 12'h305, 5'd1, 32'h0000_1003, old, ill);
    checks++; if (old !== 32'h8000_0101) begin failures++; $display("FAIL mtvec_old2 got=%h exp=80000101", old); end
    rd(12'h305, d);
    checks++; if (d !== 32'h0000_1001) begin failures++; $display("FAIL mtvec_bit1 got=%h exp=1001", d); end
    wr(3'b001, 12'h341, 5'd1, 32'h0000_0207, old, ill);
    rd(12'h341, d);
    checks++; if (d !== 32'h0000_0204) begin failures++; $display("FAIL mepc_align got=%h exp=204", d); end
  endtask

  task automatic test_set_clear();
    logic [2:0]  f3s  [10] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};
    logic [4:0]  idxs [10] = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd3, 5'd0, 5'd0, 5'd0, 5'd31, 5'd1};
    logic [31:0] vals [10] = '{32'hF0F0, 32'h000F, 32'h00F0, 32'h0, 32'h0, 32'hFFFF, 32'hFFFF,
                               32'h1234, 32'h0, 32'h0};
    logic [31:0] exps [10] = '{32'hF0F0, 32'hF0FF, 32'hF00F, 32'hF00F, 32'hF00C, 32'hF00C,
                               32'hF00C, 32'h1234, 32'h001F, 32'h001F};
    logic [31:0] d, old;
    logic ill;
    for (int i = 0; i < 10; i++) begin
      wr(f3s[i], 12'h340, idxs[i], vals[i], old, ill);
      checks++; if (ill !== (i == 9)) begin failures++; $display("FAIL setclr_ill_%0d got=%b exp=%b", i, ill, i == 9); end
      rd(12'h340, d);
      checks++; if (d !== exps[i]) begin failures++; $display("FAIL setclr_%0d got=%h exp=%h", i, d, exps[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [2:0]  f3s  [7] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
    logic [11:0] adrs [7] = '{12'h340, 12'h340, 12'h123, 12'h344, 12'h344, 12'hB00, 12'hB82};
    logic [4:0]  idxs [7] = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd1};
    logic        exps [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      csr_en = 1'b1; func3 = f3s[i]; offset = adrs[i]; rs1_idx = idxs[i]; rs1_val = 32'h1;
      #1;
      checks++; if (csr_illegal !== exps[i]) begin failures++; $display("FAIL illegal_%0d got=%b exp=%b", i, csr_illegal, exps[i]); end
      csr_en = 1'b0;
      #1;
    end
    step();
  endtask

  task automatic test_timer_trap();
    logic [31:0] d, old;
    logic ill;
    wr(3'b001, 12'h305, 5'd1, 32'h0000_1001, old, ill);
    wr(3'b001, 12'h304, 5'd1, 32'h0000_0080, old, ill);
    wr(3'b001, 12'h300, 5'd1, 32'h0000_0008, old, ill);
    checks++; if (mie_out !== 1'b1) begin failures++; $display("FAIL tmr_mie_set got=%b exp=1", mie_out); end
    tmr_irq = 1'b1;
    #1;
    checks++; if (trap_req !== 1'b1) begin failures++; $display("FAIL tmr_req got=%b exp=1", trap_req); end
    rd(12'h344, d);
    checks++; if (d !== 32'h80) begin failures++; $display("FAIL tmr_mip got=%h exp=80", d); end
    current_pc = 32'h200; trap_ack = 1'b1;
    #1;
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL tmr_redirect got=%b exp=1", redirect); end
    checks++; if (redirect_pc !== 32'h101C) begin failures++; $display("FAIL tmr_vec_pc got=%h exp=101c", redirect_pc); end
    step();
    trap_ack = 1'b0;
    #1;
    checks++; if (mie_out !== 1'b0) begin failures++; $display("FAIL tmr_mie_clr got=%b exp=0", mie_out); end
    checks++; if (trap_req !== 1'b0) begin failures++; $display("FAIL tmr_req_masked got=%b exp=0", trap_req); end
    rd(12'h341, d);
    checks++; if (d !== 32'h200) begin failures++; $display("FAIL tmr_mepc got=%h exp=200", d); end
    rd(12'h342, d);
    checks++; if (d !== 32'h8000_0007) begin failures++; $display("FAIL tmr_mcause got=%h exp=80000007", d); end
    rd(12'h300, d);
    checks++; if (d !== 32'h80) begin failures++; $display("FAIL tmr_mstatus got=%h exp=80", d); end
  endtask

  task automatic test_mret();
    logic [31:0] d;
    tmr_irq = 1'b0; ret_action = 1'b1;
    #1;
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL mret_redirect got=%b exp=1", redirect); end
    checks++; if (redirect_pc !== 32'h200) begin failures++; $display("FAIL mret_pc got=%h exp=200", redirect_pc); end
    step();
    ret_action = 1'b0;
    checks++; if (mie_out !== 1'b1) begin failures++; $display("FAIL mret_mie got=%b exp=1", mie_out); end
    rd(12'h300, d);
    checks++; if (d !== 32'h88) begin failures++; $display("FAIL mret_mstatus got=%h exp=88", d); end
  endtask

  task automatic test_exc_priority();
    logic [31:0] d, old;
    logic ill;
    wr(3'b001, 12'h304, 5'd1, 32'h0000_0880, old, ill);
    ext_irq = 1'b1; exc_valid = 1'b1; exc_code = 5'd2; current_pc = 32'h300; trap_ack = 1'b1;
    #1;
    checks++; if (redirect_pc !== 32'h1000) begin failures++; $display("FAIL exc_pc got=%h exp=1000", redirect_pc); end
    step();
    trap_ack = 1'b0; exc_valid = 1'b0; ext_irq = 1'b0;
    rd(12'h342, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL exc_mcause got=%h exp=2", d); end
    rd(12'h341, d);
    checks++; if (d !== 32'h300) begin failures++; $display("FAIL exc_mepc got=%h exp=300", d); end
    ret_action = 1'b1;
    step();
    ret_action = 1'b0;
  endtask

  task automatic test_irq_priority();
    // Each vector is {ext, sw, tmr, local[7:0]}.
    logic [10:0] vecs [4] = '{11'b0_1_1_00000011, 11'b0_0_1_00000011, 11'b0_0_0_00000011,
                              11'b1_1_0_00000000};
    logic [4:0]  codes [4] = '{5'd3, 5'd7, 5'd16, 5'd11};
    logic [31:0] pcs [4] = '{32'h100C, 32'h101C, 32'h1040, 32'h102C};
    logic [31:0] d, old;
    logic ill;
    wr(3'b001, 12'h304, 5'd1, 32'h0001_0888, old, ill);
    for (int i = 0; i < 4; i++) begin
      {ext_irq, sw_irq, tmr_irq, local_irq} = vecs[i];
      current_pc = 32'h400 + 32'(i * 4); trap_ack = 1'b1;
      #1;
      checks++; if (redirect_pc !== pcs[i]) begin failures++; $display("FAIL prio_pc_%0d got=%h exp=%h", i, redirect_pc, pcs[i]); end
      step();
      trap_ack = 1'b0; {ext_irq, sw_irq, tmr_irq, local_irq} = '0;
      rd(12'h342, d);
      checks++; if (d !== {1'b1, 26'b0, codes[i]}) begin failures++; $display("FAIL prio_cause_%0d got=%h exp=%h", i, d, {1'b1, 26'b0, codes[i]}); end
      ret_action = 1'b1;
      step();
      ret_action = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, old;
    logic ill;
    wr(3'b001, 12'h340, 5'd1, 32'h55, old, ill);
    tmr_irq = 1'b1; trap_ack = 1'b1; ret_action = 1'b1; current_pc = 32'h500;
    csr_en = 1'b1; func3 = 3'b001; offset = 12'h340; rs1_idx = 5'd1; rs1_val = 32'hDEAD;
    #1;
    checks++; if (csr_out !== 32'h55) begin failures++; $display("FAIL b2b_csr_out got=%h exp=55", csr_out); end
    checks++; if (redirect_pc !== 32'h101C) begin failures++; $display("FAIL b2b_trap_pc got=%h exp=101c", redirect_pc); end
    step();
    csr_en = 1'b0; tmr_irq = 1'b0; trap_ack = 1'b0; ret_action = 1'b0;
    rd(12'h340, d);
    checks++; if (d !== 32'h55) begin failures++; $display("FAIL b2b_drop_write got=%h exp=55", d); end
    rd(12'h341, d);
    checks++; if (d !== 32'h500) begin failures++; $display("FAIL b2b_mepc got=%h exp=500", d); end
    ret_action = 1'b1;
    csr_en = 1'b1; func3 = 3'b001; offset = 12'h340; rs1_idx = 5'd1; rs1_val = 32'hBEEF;
    #1;
    checks++; if (redirect_pc !== 32'h500) begin failures++; $display("FAIL b2b_ret_pc got=%h exp=500", redirect_pc); end
    step();
    csr_en = 1'b0; ret_action = 1'b0;
    rd(12'h340, d);
    checks++; if (d !== 32'h55) begin failures++; $display("FAIL b2b_ret_drop got=%h exp=55", d); end
    checks++; if (mie_out !== 1'b1) begin failures++; $display("FAIL b2b_mie got=%b exp=1", mie_out); end
    trap_ack = 1'b1; current_pc = 32'h600;
    #1;
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL noreq_redirect got=%b exp=0", redirect); end
    step();
    trap_ack = 1'b0;
    rd(12'h341, d);
    checks++; if (d !== 32'h500) begin failures++; $display("FAIL noreq_mepc got=%h exp=500", d); end
  endtask

  task automatic test_counters();
    logic [31:0] d, old;
    logic ill;
`ifdef CSR_COUNTERS_EN
    wr(3'b001, 12'hB80, 5'd1, 32'h0, old, ill);
    wr(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, old, ill);
    step();
    rd(12'hB80, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL mcycleh_carry got=%h exp=1", d); end
    rd(12'hB00, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL mcycle_wrap got=%h exp=0", d); end
    wr(3'b001, 12'hB00, 5'd1, 32'h5, old, ill);
    rd(12'hB00, d);
    checks++; if (d !== 32'h5) begin failures++; $display("FAIL mcycle_wr_wins got=%h exp=5", d); end
    wr(3'b001, 12'hB82, 5'd1, 32'h7, old, ill);
    instr_retire = 1'b1;
    wr(3'b001, 12'hB02, 5'd1, 32'd10, old, ill);
    step(); step();
    instr_retire = 1'b0;
    rd(12'hB02, d);
    checks++; if (d !== 32'd12) begin failures++; $display("FAIL minstret got=%h exp=c", d); end
    rd(12'hB82, d);
    checks++; if (d !== 32'h7) begin failures++; $display("FAIL minstreth got=%h exp=7", d); end
`else
    wr(3'b001, 12'hB00, 5'd1, 32'h1234, old, ill);
    checks++; if (ill !== 1'b0) begin failures++; $display("FAIL nocnt_ill got=%b exp=0", ill); end
    rd(12'hB00, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL nocnt_mcycle got=%h exp=0", d); end
    rd(12'hB82, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL nocnt_minstreth got=%h exp=0", d); end
`endif
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    step();
    tmr_irq = 1'b1; trap_ack = 1'b1; ret_action = 1'b1; current_pc = 32'h700;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL abort_redirect got=%b exp=0", redirect); end
    checks++; if (mie_out !== 1'b0) begin failures++; $display("FAIL abort_mie got=%b exp=0", mie_out); end
    step();
    tmr_irq = 1'b0; trap_ack = 1'b0; ret_action = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd(csr_addrs[i], d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL abort_csr_%h got=%h exp=0", csr_addrs[i], d); end
    end
    reset = 1'b0;
    step();
    rd(12'h341, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL abort_mepc_after got=%h exp=0", d); end
  endtask

  initial begin
    #1;
    test_reset();
    test_mtvec_rw();
    test_set_clear();
    test_illegal();
    test_timer_trap();
    test_mret();
    test_exc_priority();
    test_irq_priority();
    test_back_to_back();
    test_counters();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 supported, checked at elaboration.
REQ-002 SHALL have parameter NUM_IRQ, default 8, local interrupt lines (1..16), mapped to mip/mie bits [16+NUM_IRQ-1:16].
REQ-003 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- csr_en  in  1  CSR instruction valid.
- func3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- offset  in  12  CSR address.
- rs1_idx  in  5  rs1 index / uimm.
- rs1_val  in  XLEN  RS1 value.
- csr_out  out  XLEN  old CSR value for rd.
- csr_illegal  out  1  unimplemented address or func3.
- ext_irq, tmr_irq, sw_irq  in  1 each  level interrupts, mip bits 11/7/3.
- local_irq  in  NUM_IRQ  level local interrupts.
- exc_valid  in  1  synchronous exception.
- exc_code  in  5  exception cause.
- ret_action  in  1  mret retiring.
- current_pc  in  XLEN  PC of the instruction being retired/trapped.
- instr_retire  in  1  one instruction retired this cycle.
- trap_req  out  1  trap pending (combinational).
- trap_ack  in  1  core commits the trap this cycle.
- redirect  out  1  PC redirect this cycle.
- redirect_pc  out  XLEN  redirect target.
- MIE  out  1  mstatus.MIE.

Function
REQ-004 SHALL implement mstatus 0x300 (MIE bit3, MPIE bit7, others read 0), mie 0x304, mtvec 0x305, mepc 0x341, mscratch 0x340, mcause 0x342, mip 0x344 (read-only).
REQ-005 SHALL drive csr_out combinationally with the pre-write value; the write takes effect at the next clk edge.
REQ-006 SHALL compute new = src (RW), old|src (RS), old&~src (RC); src = rs1_val, or zero-extended rs1_idx for the I forms.
REQ-007 SHALL suppress the write for RS/RC/RSI/RCI when rs1_idx==0; RW always writes.
REQ-008 SHALL assert csr_illegal combinationally, with no state change, for an unmapped offset, a write to mip, or func3 000/100.
REQ-009 SHALL force mepc[1:0]=0 and mtvec[1] to 0 on write; mtvec[0]=1 selects vectored mode.
REQ-010 SHALL assert trap_req when exc_valid, or when MIE and any (mip&mie) bit is set.
REQ-011 SHALL apply this cause priority: exception > ext (11) > sw (3) > tmr (7) > local, lowest local index first; mcause[31] = interrupt flag.
REQ-012 SHALL, on trap_ack with trap_req, in one edge: mepc<=current_pc, mcause<=cause, MPIE<=MIE, MIE<=0.
REQ-013 SHALL, in that cycle, assert redirect with redirect_pc = mtvec base for exceptions or direct mode, and base+4*cause for vectored interrupts.
REQ-014 SHALL, on ret_action: MIE<=MPIE, MPIE<=1, redirect=1, redirect_pc=mepc.
REQ-015 SHALL resolve simultaneous events as trap_ack > ret_action > CSR write; the losing write is dropped and csr_out stays valid.
REQ-016 SHALL treat trap_ack without trap_req as no-op.

Reset
REQ-017 SHALL clear all CSRs to 0 asynchronously on reset, including mtvec; redirect, trap_req and csr_illegal read 0 during reset.
REQ-018 SHALL let reset abort a same-cycle trap_ack or ret_action with no state update.

Configuration
REQ-019 With CSR_COUNTERS_EN defined, SHALL implement 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), readable and writable.
REQ-020 mcycle SHALL increment every cycle and minstret on instr_retire; a CSR write to either half wins over that cycle's increment; wrap is 2^64-1 -> 0 with carry into the high half.
REQ-021 Without CSR_COUNTERS_EN, SHALL read 0xB00/0xB02/0xB80/0xB82 as 0 and ignore writes, without asserting csr_illegal.

Verification
REQ-022 Scenario: CSRRW 0x305 with rs1_val=0x8000_0101 -> csr_out=0, next read 0x8000_0101.
REQ-023 Scenario: mtvec=0x1001, mie[7]=1, MIE=1, tmr_irq=1, trap_ack, current_pc=0x200 -> redirect_pc=0x101C, mepc=0x200, mcause=0x8000_0007, MIE=0, MPIE=1.
REQ-024 Scenario: exc_valid with exc_code=2 and ext_irq both pending -> mcause=2, redirect_pc=0x1000 in vectored mode.
REQ-025 Scenario: mret after REQ-023 -> redirect_pc=0x200, MIE=1; CSRRS 0x344 with rs1_idx=0 -> no illegal, no write; CSRRW 0x344 -> csr_illegal=1.
REQ-026 Scenario (CSR_COUNTERS_EN): mcycleh=0, mcycle=0xFFFF_FFFF, one clk -> mcycleh=1, mcycle=0; write mcycle=5 same cycle -> reads 5.
REQ-027 Scenario: reset asserted mid-cycle with trap_ack=1 -> all CSRs 0, redirect=0.
